// File: rtl/rv_pkg.sv
// Shared RV32I constants for the data memory stage: major opcodes, load/store
// width encodings and the stage FSM state type.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    F3_B  = 3'd0,
    F3_H  = 3'd1,
    F3_W  = 3'd2,
    F3_BU = 3'd4,
    F3_HU = 3'd5
  } funct3_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/data_mem_stage_if.sv
// Execute-side and writeback-side handshake bundle of the data memory stage.
// master = upstream/writeback environment, slave = the stage itself.
interface data_mem_stage_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] ir;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ir_out;
  logic [31:0] a_out;
  logic [31:0] pc_out;
  logic [31:0] rd_out;
  logic        fault_out;

  modport master (
    output in_valid, ir, a, b, pc, out_ready,
    input  in_ready, out_valid, ir_out, a_out, pc_out, rd_out, fault_out
  );

  modport slave (
    input  in_valid, ir, a, b, pc, out_ready,
    output in_ready, out_valid, ir_out, a_out, pc_out, rd_out, fault_out
  );

endinterface

// File: rtl/data_mem_stage_byte_lane_ram.sv
// Word-organised RAM built from four independent byte lanes; per-lane
// synchronous write and a synchronous 32-bit read, both on one address port.
module byte_lane_ram #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic [3:0]        we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [0:(2**ADDR_W)-1];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
      if (we_i[l]) mem[addr_i] <= wdata_i[8*l +: 8];
      if (re_i)    rdata_q     <= mem[addr_i];
    end

    assign rdata_o[8*l +: 8] = rdata_q;
  end

endmodule

// File: rtl/data_mem_stage.sv
// RV32I memory stage: byte-addressed loads/stores with lane steering, LAT-cycle
// completion and valid/ready on both sides. DATA_MEM_MISALIGN_TRAP_EN makes misaligned H/W accesses fault.
module data_mem_stage
  import rv_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LAT    = 1
) (
  input logic             clk,
  input logic             rst_n,
  data_mem_stage_if.slave mem_if
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_MISALIGN = 1'b1;
`else
  localparam bit TRAP_MISALIGN = 1'b0;
`endif

  function automatic logic ld_illegal(input logic [2:0] f3);
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  // Without the trap, halfword/word accesses silently round down to alignment.
  function automatic logic [1:0] eff_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return {off[1], 1'b0};
      2'b10:   return 2'b00;
      default: return off;
    endcase
  endfunction

  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [1:0] off,
                                      input logic [31:0] word);
    logic [7:0]  byt;
    logic [15:0] half;
    byt  = word[8*off +: 8];
    half = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    return {{24{byt[7]}}, byt};
      F3_BU:   return {24'd0, byt};
      F3_H:    return {{16{half[15]}}, half};
      F3_HU:   return {16'd0, half};
      F3_W:    return word;
      default: return 32'd0;
    endcase
  endfunction

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       ir_q, a_q, b_q, pc_q;
  logic              out_valid_q, fault_q;
  logic [31:0]       ir_out_q, a_out_q, pc_out_q;
  logic [31:0]       ram_rdata;

  logic        in_ready, accept, complete;
  logic [31:0] cur_ir, cur_a, cur_b, cur_pc;
  logic [2:0]  f3;
  logic [1:0]  eoff;
  logic        is_load, is_store, is_mem, fault_c;
  logic [3:0]  lane_mask, ram_we;
  logic [31:0] wdata;
  logic        ram_re;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || mem_if.out_ready);
  assign accept   = mem_if.in_valid && in_ready;

  // In WAIT the op under way is the latched one; in IDLE it is the one being offered.
  assign cur_ir = (state_q == S_WAIT) ? ir_q : mem_if.ir;
  assign cur_a  = (state_q == S_WAIT) ? a_q  : mem_if.a;
  assign cur_b  = (state_q == S_WAIT) ? b_q  : mem_if.b;
  assign cur_pc = (state_q == S_WAIT) ? pc_q : mem_if.pc;

  assign f3       = cur_ir[14:12];
  assign eoff     = eff_off(f3, cur_a[1:0]);
  assign is_load  = (cur_ir[6:0] == OPC_LOAD);
  assign is_store = (cur_ir[6:0] == OPC_STORE);
  assign is_mem   = is_load || is_store;
  assign fault_c  = (is_load && ld_illegal(f3)) || (is_store && (f3 >= 3'd3)) ||
                    (is_mem && TRAP_MISALIGN && misaligned(f3, cur_a[1:0]));

  assign complete = ((state_q == S_IDLE) && accept && (!is_mem || (LAT == 1))) ||
                    ((state_q == S_WAIT) && (cnt_q == CNT_W'(1)));

  always_comb begin
    lane_mask = 4'b1111;
    wdata     = cur_b;
    case (f3[1:0])
      2'b00: begin
        lane_mask = 4'b0001 << eoff;
        wdata     = {4{cur_b[7:0]}};
      end
      2'b01: begin
        lane_mask = eoff[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{cur_b[15:0]}};
      end
      default: ;
    endcase
  end

  assign ram_we = (complete && is_store && !fault_c) ? lane_mask : 4'b0000;
  assign ram_re = complete && is_load && !fault_c;

  byte_lane_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (cur_a[ADDR_W+1:2]),
    .wdata_i (wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept && is_mem && (LAT > 1)) begin
        state_d = S_WAIT;
        cnt_d   = CNT_W'(LAT - 1);
      end
      S_WAIT: if (cnt_q == CNT_W'(1)) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ir_q <= mem_if.ir;
      a_q  <= mem_if.a;
      b_q  <= mem_if.b;
      pc_q <= mem_if.pc;
    end
  end

  // A completion only ever lands in a free slot, so it may overwrite unconditionally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ir_out_q    <= '0;
      a_out_q     <= '0;
      pc_out_q    <= '0;
      fault_q     <= 1'b0;
    end else if (complete) begin
      out_valid_q <= 1'b1;
      ir_out_q    <= cur_ir;
      a_out_q     <= cur_a;
      pc_out_q    <= cur_pc;
      fault_q     <= fault_c;
    end else if (out_valid_q && mem_if.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign mem_if.in_ready  = in_ready;
  assign mem_if.out_valid = out_valid_q;
  assign mem_if.ir_out    = ir_out_q;
  assign mem_if.a_out     = a_out_q;
  assign mem_if.pc_out    = pc_out_q;
  assign mem_if.fault_out = fault_q;
  // Read data sits in the RAM output register; extension is applied on the way out.
  assign mem_if.rd_out    = ((ir_out_q[6:0] == OPC_LOAD) && !fault_q) ?
                            ext(ir_out_q[14:12], eff_off(ir_out_q[14:12], a_out_q[1:0]), ram_rdata) :
                            32'd0;

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: one LAT=1 instance for load/store function
// and one LAT=3 instance for stall, latency and reset-abort behaviour.
module tb_data_mem_stage;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  logic clk = 1'b0;
  logic rst1_n, rst3_n;
  always #5 clk = ~clk;

  data_mem_stage_if if1();
  data_mem_stage_if if3();

  data_mem_stage #(.ADDR_W(16), .LAT(1)) u1 (.clk(clk), .rst_n(rst1_n), .mem_if(if1));
  data_mem_stage #(.ADDR_W(16), .LAT(3)) u3 (.clk(clk), .rst_n(rst3_n), .mem_if(if3));

  int errors = 0;
  int checks = 0;

  logic [31:0] w;
  logic        exp_mis_fault;
  logic [31:0] exp_mis_lh;
  int          lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, opc};
  endfunction

  task automatic op1(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] pc);
    @(negedge clk);
    if1.ir = ir; if1.a = a; if1.b = b; if1.pc = pc;
    if1.in_valid = 1'b1;
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
  endtask

  // Returns edges waited after the accept edge before out_valid was seen.
  task automatic op3(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                     output int edges);
    logic ok;
    @(negedge clk);
    if3.ir = ir; if3.a = a; if3.b = b; if3.pc = 32'h300;
    if3.out_ready = 1'b1;
    if3.in_valid  = 1'b1;
    @(posedge clk); #1;
    if3.in_valid = 1'b0;
    ok = 1'b0;
    edges = 0;
    for (int n = 0; n < 8 && !ok; n++) begin
      if (if3.out_valid) ok = 1'b1;
      else begin
        @(posedge clk); #1;
        edges++;
      end
    end
    chk("op3_completion_timeout", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    exp_mis_fault = 1'b1;
    w             = 32'hDEADBEEF;
    exp_mis_lh    = 32'h0000_0000;
`else
    exp_mis_fault = 1'b0;
    w             = 32'h11111111;
    exp_mis_lh    = 32'h0000_1111;
`endif
    if1.in_valid = 1'b0; if1.out_ready = 1'b1;
    if1.ir = '0; if1.a = '0; if1.b = '0; if1.pc = '0;
    if3.in_valid = 1'b0; if3.out_ready = 1'b1;
    if3.ir = '0; if3.a = '0; if3.b = '0; if3.pc = '0;
    rst1_n = 1'b0; rst3_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, if1.out_valid}, 32'd0);
    chk("rst_ir_out",    if1.ir_out, 32'd0);
    chk("rst_a_out",     if1.a_out,  32'd0);
    chk("rst_pc_out",    if1.pc_out, 32'd0);
    chk("rst_rd_out",    if1.rd_out, 32'd0);
    chk("rst_fault",     {31'd0, if1.fault_out}, 32'd0);
    chk("rst3_out_valid", {31'd0, if3.out_valid}, 32'd0);
    @(negedge clk);
    rst1_n = 1'b1; rst3_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, if1.in_ready}, 32'd1);

    // Basic store/load and byte/halfword lane steering
    op1(mk(ST, 3'd2), 32'h100, 32'hDEADBEEF, 32'h10);
    chk("sw_valid", {31'd0, if1.out_valid}, 32'd1);
    chk("sw_fault", {31'd0, if1.fault_out}, 32'd0);
    chk("sw_rd",    if1.rd_out, 32'd0);
    chk("sw_a_out", if1.a_out, 32'h100);
    chk("sw_pc_out", if1.pc_out, 32'h10);
    op1(mk(LD, 3'd2), 32'h100, 32'h0, 32'h14);
    chk("lw_rd", if1.rd_out, 32'hDEADBEEF);
    chk("lw_fault", {31'd0, if1.fault_out}, 32'd0);
    op1(mk(ST, 3'd0), 32'h103, 32'h00000080, 32'h18);
    op1(mk(LD, 3'd0), 32'h103, 32'h0, 32'h1C);
    chk("lb_rd", if1.rd_out, 32'hFFFFFF80);
    op1(mk(LD, 3'd4), 32'h103, 32'h0, 32'h20);
    chk("lbu_rd", if1.rd_out, 32'h00000080);
    op1(mk(LD, 3'd2), 32'h100, 32'h0, 32'h24);
    chk("lw_after_sb", if1.rd_out, 32'h80ADBEEF);

    op1(mk(ST, 3'd2), 32'h100, 32'hDEADBEEF, 32'h28);
    op1(mk(LD, 3'd1), 32'h102, 32'h0, 32'h2C);
    chk("lh_hi", if1.rd_out, 32'hFFFFDEAD);
    op1(mk(LD, 3'd5), 32'h102, 32'h0, 32'h30);
    chk("lhu_hi", if1.rd_out, 32'h0000DEAD);
    op1(mk(LD, 3'd1), 32'h100, 32'h0, 32'h34);
    chk("lh_lo", if1.rd_out, 32'hFFFFBEEF);
    op1(mk(LD, 3'd0), 32'h101, 32'h0, 32'h38);
    chk("lb_lane1", if1.rd_out, 32'hFFFFFFBE);
    op1(mk(LD, 3'd4), 32'h100, 32'h0, 32'h3C);
    chk("lbu_lane0", if1.rd_out, 32'h000000EF);
    op1(mk(ST, 3'd1), 32'h102, 32'h0000A55A, 32'h40);
    op1(mk(LD, 3'd2), 32'h100, 32'h0, 32'h44);
    chk("lw_after_sh", if1.rd_out, 32'hA55ABEEF);
    op1(mk(ST, 3'd2), 32'h100, 32'hDEADBEEF, 32'h48);

    // Misaligned word store and halfword load
    op1(mk(ST, 3'd2), 32'h101, 32'h11111111, 32'h4C);
    chk("sw_mis_fault", {31'd0, if1.fault_out}, {31'd0, exp_mis_fault});
    op1(mk(LD, 3'd2), 32'h100, 32'h0, 32'h50);
    chk("lw_after_mis_sw", if1.rd_out, w);
    op1(mk(LD, 3'd1), 32'h101, 32'h0, 32'h54);
    chk("lh_mis_fault", {31'd0, if1.fault_out}, {31'd0, exp_mis_fault});
    chk("lh_mis_rd", if1.rd_out, exp_mis_lh);

    // Illegal funct3 faults with no side effect
    op1(mk(LD, 3'd3), 32'h100, 32'h0, 32'h58);
    chk("ld_f3_3_fault", {31'd0, if1.fault_out}, 32'd1);
    chk("ld_f3_3_rd", if1.rd_out, 32'd0);
    op1(mk(LD, 3'd7), 32'h100, 32'h0, 32'h5C);
    chk("ld_f3_7_fault", {31'd0, if1.fault_out}, 32'd1);
    op1(mk(ST, 3'd3), 32'h100, 32'h0, 32'h60);
    chk("st_f3_3_fault", {31'd0, if1.fault_out}, 32'd1);
    op1(mk(LD, 3'd2), 32'h100, 32'h0, 32'h64);
    chk("lw_after_bad_st", if1.rd_out, w);
    chk("lw_after_bad_st_fault", {31'd0, if1.fault_out}, 32'd0);

    // Upper address bits beyond the RAM wrap
    op1(mk(LD, 3'd2), 32'h40100, 32'h0, 32'h68);
    chk("lw_wrap", if1.rd_out, w);

    // Pass-through op
    op1(32'h00500093, 32'h1234, 32'h0, 32'h6C);
    chk("pt_valid", {31'd0, if1.out_valid}, 32'd1);
    chk("pt_ir_out", if1.ir_out, 32'h00500093);
    chk("pt_a_out", if1.a_out, 32'h1234);
    chk("pt_pc_out", if1.pc_out, 32'h6C);
    chk("pt_rd", if1.rd_out, 32'd0);
    chk("pt_fault", {31'd0, if1.fault_out}, 32'd0);

    // Back-to-back accepts at full throughput
    @(negedge clk);
    if1.ir = mk(LD, 3'd2); if1.a = 32'h100; if1.pc = 32'h70; if1.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b_first", if1.rd_out, w);
    chk("b2b_in_ready", {31'd0, if1.in_ready}, 32'd1);
    if1.ir = mk(LD, 3'd4); if1.pc = 32'h74;
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    chk("b2b_second", if1.rd_out, {24'd0, w[7:0]});
    chk("b2b_pc", if1.pc_out, 32'h74);
    @(posedge clk); #1;
    chk("drain_out_valid", {31'd0, if1.out_valid}, 32'd0);

    // LAT=3 with writeback stalled
    @(negedge clk);
    if3.ir = mk(ST, 3'd2); if3.a = 32'h200; if3.b = 32'hCAFEF00D; if3.pc = 32'h80;
    if3.out_ready = 1'b0; if3.in_valid = 1'b1;
    @(posedge clk); #1;
    if3.in_valid = 1'b0;
    chk("l3_acc_in_ready", {31'd0, if3.in_ready}, 32'd0);
    chk("l3_acc_out_valid", {31'd0, if3.out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("l3_w1_out_valid", {31'd0, if3.out_valid}, 32'd0);
    chk("l3_w1_in_ready", {31'd0, if3.in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("l3_done_out_valid", {31'd0, if3.out_valid}, 32'd1);
    chk("l3_done_a_out", if3.a_out, 32'h200);
    chk("l3_done_in_ready", {31'd0, if3.in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("l3_hold_out_valid", {31'd0, if3.out_valid}, 32'd1);
    chk("l3_hold_ir_out", if3.ir_out, mk(ST, 3'd2));
    chk("l3_hold_pc_out", if3.pc_out, 32'h80);
    chk("l3_hold_in_ready", {31'd0, if3.in_ready}, 32'd0);
    @(negedge clk);
    if3.out_ready = 1'b1;
    #1;
    chk("l3_release_in_ready", {31'd0, if3.in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("l3_release_out_valid", {31'd0, if3.out_valid}, 32'd0);

    op3(mk(LD, 3'd2), 32'h200, 32'h0, lat);
    chk("l3_lw_rd", if3.rd_out, 32'hCAFEF00D);
    chk("l3_lw_latency", lat, 2);
    op3(32'h00000013, 32'h55, 32'h0, lat);
    chk("l3_pt_latency", lat, 0);

    // Reset during WAIT drops the pending store
    @(negedge clk);
    if3.ir = mk(ST, 3'd2); if3.a = 32'h200; if3.b = 32'h12345678; if3.in_valid = 1'b1;
    @(posedge clk); #1;
    if3.in_valid = 1'b0;
    chk("l3_rst_wait_in_ready", {31'd0, if3.in_ready}, 32'd0);
    @(negedge clk);
    rst3_n = 1'b0;
    #1;
    chk("l3_rst_out_valid", {31'd0, if3.out_valid}, 32'd0);
    chk("l3_rst_in_ready", {31'd0, if3.in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("l3_rst_hold_out_valid", {31'd0, if3.out_valid}, 32'd0);
    @(negedge clk);
    rst3_n = 1'b1;
    @(posedge clk); #1;
    chk("l3_post_rst_out_valid", {31'd0, if3.out_valid}, 32'd0);
    op3(mk(LD, 3'd2), 32'h200, 32'h0, lat);
    chk("l3_lw_after_abort", if3.rd_out, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
